// File: rtl/hex_segment_capture.sv
// -----------------------------------------------------------------------------
// hex_segment_capture
//
// Reads back a scanned, multiplexed, active-low 7-segment bus and recovers
// the hex digits it shows. This is the reverse of the hex-to-7-segment
// display path. Self-check logic and board loopback use it.
//
// Pipeline:
//   1. A sample register captures HEX and digit_sel.
//   2. A stability filter waits for STABLE_CYCLES identical samples on an
//      exactly one-hot digit_sel.
//   3. A glyph decoder maps the active-high pattern to a nibble and a bad flag.
//   4. A frame FSM (IDLE -> SCAN -> DONE) keeps the first stable glyph of each
//      digit and packs the results into one value.
//
// Ports:
//   clock        in   1             single clock, rising edge
//   reset        in   1             asynchronous, active-high
//   HEX          in   7             active-low segments, HEX[0]=a .. HEX[6]=g
//   digit_sel    in   NUM_DIGITS    one-hot strobe for the digit on HEX
//   start        in   1             one-cycle pulse that begins a frame
//   value        out  4*NUM_DIGITS  digit i at value[4i+3:4i]
//   bad_digit    out  NUM_DIGITS    digit i was not a legal hex glyph
//   busy         out  1             high while scanning
//   done         out  1             one-cycle pulse on frame completion
//   timeout      out  1             one-cycle pulse on frame abort
//   blank_digit  out  NUM_DIGITS    digit i showed all segments off
//                                   (present only with HEX_SEGMENT_BLANK_EN)
//
// Build option:
//   HEX_SEGMENT_BLANK_EN  When defined, the all-off pattern is a legal
//                         "blank" glyph (nibble 0, not bad) and the
//                         blank_digit output is added. When undefined,
//                         all-off is an illegal glyph.
// -----------------------------------------------------------------------------
module hex_segment_capture #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [6:0]              HEX,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    input  logic                    start,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   bad_digit,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout
`ifdef HEX_SEGMENT_BLANK_EN
    ,
    output logic [NUM_DIGITS-1:0]   blank_digit
`endif
);

    // The stability counter saturates at STABLE_CYCLES, so it needs room for
    // that value. The timeout counter only has to reach TIMEOUT_CYCLES-1.
    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [STAB_W-1:0]     STAB_MAX = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0]     STAB_ONE = STAB_W'(1);
    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]      TMO_ONE  = TMO_W'(1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {bad, nibble} for an active-low segment pattern.
    function automatic logic [4:0] decode_glyph(input logic [6:0] hex_n);
        logic [4:0] r;
        r = 5'b1_0000;
        case (~hex_n)
            7'h3F: r = 5'h00;
            7'h06: r = 5'h01;
            7'h5B: r = 5'h02;
            7'h4F: r = 5'h03;
            7'h66: r = 5'h04;
            7'h6D: r = 5'h05;
            7'h7D: r = 5'h06;
            7'h07: r = 5'h07;
            7'h7F: r = 5'h08;
            7'h6F: r = 5'h09;
            7'h77: r = 5'h0A;
            7'h7C: r = 5'h0B;
            7'h39: r = 5'h0C;
            7'h5E: r = 5'h0D;
            7'h79: r = 5'h0E;
            7'h71: r = 5'h0F;
`ifdef HEX_SEGMENT_BLANK_EN
            7'h00: r = 5'h00;
`endif
            default: r = 5'b1_0000;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Sample stage and stability filter
    // ------------------------------------------------------------------------
    logic [6:0]            smp_hex;
    logic [NUM_DIGITS-1:0] smp_sel;
    logic [6:0]            prv_hex;
    logic [NUM_DIGITS-1:0] prv_sel;
    logic [STAB_W-1:0]     stab_cnt;   // run length of the previous sample
    logic [STAB_W-1:0]     run_len;    // run length of the current sample
    logic                  sel_onehot;
    logic                  accept;

    // NOTE: sequential state uses non-blocking assignments, so every register
    // in this block updates from the values held before the edge. That is
    // what lets prv_* pick up the old smp_* in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            smp_hex  <= '0;
            smp_sel  <= '0;
            prv_hex  <= '0;
            prv_sel  <= '0;
            stab_cnt <= '0;
        end else begin
            smp_hex  <= HEX;
            smp_sel  <= digit_sel;
            prv_hex  <= smp_hex;
            prv_sel  <= smp_sel;
            stab_cnt <= run_len;
        end
    end

    // NOTE: every always_comb output gets a default before any branch. No
    // path then leaves a signal unassigned, so no latch is inferred.
    always_comb begin
        run_len = STAB_ONE;
        if ((smp_hex == prv_hex) && (smp_sel == prv_sel)) begin
            if (stab_cnt >= STAB_MAX) begin
                run_len = STAB_MAX;
            end else begin
                run_len = stab_cnt + STAB_ONE;
            end
        end
    end

    // Zero-hot and multi-hot strobes never qualify a digit.
    assign sel_onehot = (smp_sel != '0) && ((smp_sel & (smp_sel - SEL_ONE)) == '0);

    // The acceptance level is held for as long as the digit stays steady.
    // A digit that was already stable when start arrived is therefore still
    // picked up.
    assign accept = (run_len == STAB_MAX) && sel_onehot;

    logic [4:0] glyph;
    logic [3:0] glyph_nib;
    logic       glyph_bad;

    assign glyph     = decode_glyph(smp_hex);
    assign glyph_nib = glyph[3:0];
    assign glyph_bad = glyph[4];

`ifdef HEX_SEGMENT_BLANK_EN
    logic glyph_blank;
    assign glyph_blank = (smp_hex == 7'h7F);
`endif

    // ------------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------------
    state_t                state;
    state_t                state_nxt;
    logic [NUM_DIGITS-1:0] seen;
    logic [TMO_W-1:0]      tmo_cnt;
    logic                  clr_frame;
    logic                  tmo_hit;
    logic [NUM_DIGITS-1:0] wr_en;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        clr_frame = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SCAN;
                    clr_frame = 1'b1;
                end
            end
            SCAN: begin
                busy = 1'b1;
                // A frame that fills on the last allowed cycle completes.
                // It does not abort.
                if (&seen) begin
                    state_nxt = DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = IDLE;
                    tmo_hit   = 1'b1;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // First stable glyph wins: digits already seen in this frame are masked.
    assign wr_en = (busy && accept) ? (smp_sel & ~seen) : '0;

    // ------------------------------------------------------------------------
    // Frame datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seen        <= '0;
            tmo_cnt     <= '0;
            value       <= '0;
            bad_digit   <= '0;
            timeout     <= 1'b0;
`ifdef HEX_SEGMENT_BLANK_EN
            blank_digit <= '0;
`endif
        end else begin
            timeout <= tmo_hit;

            if (clr_frame) begin
                seen    <= '0;
                tmo_cnt <= '0;
            end else if (busy) begin
                seen <= seen | wr_en;
                if (!tmo_hit) begin
                    tmo_cnt <= tmo_cnt + TMO_ONE;
                end
            end

            // value and bad_digit persist across frames. Only digits
            // accepted in the current frame are overwritten.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_en[i]) begin
                    value[4*i +: 4] <= glyph_nib;
                    bad_digit[i]    <= glyph_bad;
`ifdef HEX_SEGMENT_BLANK_EN
                    blank_digit[i]  <= glyph_blank;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_hex_segment_capture.sv
// -----------------------------------------------------------------------------
// tb_hex_segment_capture
//
// Directed frames plus randomized scanning, checked each cycle against a
// behavioural model. The model holds:
//   - a sample history queue,
//   - a glyph table lookup,
//   - a frame record (phase, age, seen mask).
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_hex_segment_capture;

    localparam int ND = 4;
    localparam int SC = 3;
    localparam int TC = 64;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [6:0]        HEX = 7'h7F;
    logic [ND-1:0]     digit_sel = '0;
    logic              start = 1'b0;
    logic [4*ND-1:0]   value;
    logic [ND-1:0]     bad_digit;
    logic              busy;
    logic              done;
    logic              timeout;
`ifdef HEX_SEGMENT_BLANK_EN
    logic [ND-1:0]     blank_digit;
`endif

    always #5 clock = ~clock;

    hex_segment_capture #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .HEX        (HEX),
        .digit_sel  (digit_sel),
        .start      (start),
        .value      (value),
        .bad_digit  (bad_digit),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout)
`ifdef HEX_SEGMENT_BLANK_EN
        ,
        .blank_digit(blank_digit)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [6:0]    hex;
        logic [ND-1:0] sel;
    } smp_t;

    smp_t            hist[$];
    logic [4*ND-1:0] m_value;
    logic [ND-1:0]   m_bad;
    logic [ND-1:0]   m_blank;
    logic [ND-1:0]   m_seen;
    int              m_phase;     // 0 idle, 1 scanning, 2 done cycle
    int              m_age;       // cycles spent scanning
    bit              m_timeout;
    bit              pend_acc;
    int              pend_digit;
    logic [3:0]      pend_nib;
    bit              pend_bad;
    bit              pend_blank;

    function automatic void decode(input logic [6:0] hx, output logic [3:0] nib,
                                   output bit is_bad, output bit is_blank);
        logic [6:0] seg;
        seg      = ~hx;
        nib      = 4'h0;
        is_bad   = 1'b1;
        is_blank = 1'b0;
        for (int g = 0; g < 16; g++) begin
            if (GLYPH[g] == seg) begin
                nib    = 4'(g);
                is_bad = 1'b0;
            end
        end
`ifdef HEX_SEGMENT_BLANK_EN
        if (seg == 7'h00) begin
            is_bad   = 1'b0;
            is_blank = 1'b1;
        end
`endif
    endfunction

    task automatic model_reset();
        smp_t z;
        z = '0;
        hist.delete();
        hist.push_back(z);
        m_value   = '0;
        m_bad     = '0;
        m_blank   = '0;
        m_seen    = '0;
        m_phase   = 0;
        m_age     = 0;
        m_timeout = 1'b0;
        pend_acc  = 1'b0;
    endtask

    task automatic model_edge(input bit st, input logic [6:0] hx, input logic [ND-1:0] sl);
        bit   full;
        bit   eq;
        smp_t s;
        full      = (m_seen == '1);
        m_timeout = 1'b0;
        case (m_phase)
            0: begin
                if (st) begin
                    m_phase = 1;
                    m_seen  = '0;
                    m_age   = 0;
                end
            end
            1: begin
                if (full) begin
                    m_phase = 2;
                end else begin
                    if (pend_acc && !m_seen[pend_digit]) begin
                        m_value[4*pend_digit +: 4] = pend_nib;
                        m_bad[pend_digit]          = pend_bad;
                        m_blank[pend_digit]        = pend_blank;
                        m_seen[pend_digit]         = 1'b1;
                    end
                    if (m_age == TC - 1) begin
                        m_phase   = 0;
                        m_timeout = 1'b1;
                    end else begin
                        m_age++;
                    end
                end
            end
            default: m_phase = 0;
        endcase

        s.hex = hx;
        s.sel = sl;
        hist.push_back(s);
        if (hist.size() > SC) void'(hist.pop_front());

        pend_acc = 1'b0;
        if (hist.size() == SC && $countones(sl) == 1) begin
            eq = 1'b1;
            for (int h = 1; h < hist.size(); h++) begin
                if (hist[h] != hist[0]) eq = 1'b0;
            end
            if (eq) begin
                pend_acc = 1'b1;
                for (int b = 0; b < ND; b++) begin
                    if (sl[b]) pend_digit = b;
                end
                decode(hx, pend_nib, pend_bad, pend_blank);
            end
        end
    endtask

    task automatic check_outputs();
        check("value",     value,     m_value);
        check("bad_digit", bad_digit, m_bad);
        check("busy",      busy,      m_phase == 1);
        check("done",      done,      m_phase == 2);
        check("timeout",   timeout,   m_timeout);
`ifdef HEX_SEGMENT_BLANK_EN
        check("blank_digit", blank_digit, m_blank);
`endif
    endtask

    // Called at a falling edge. Drives one cycle, steps the model, and
    // checks at the next falling edge.
    task automatic cyc(input bit st, input logic [6:0] hx, input logic [ND-1:0] sl);
        start     = st;
        HEX       = hx;
        digit_sel = sl;
        @(posedge clock);
        model_edge(st, hx, sl);
        @(negedge clock);
        check_outputs();
        if (done) done_cnt++;
    endtask

    task automatic hold(input logic [6:0] hx, input logic [ND-1:0] sl, input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, hx, sl);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int         d0;
        int         t_at;
        int         done_at_timeout;
        logic [6:0] rh;
        logic [ND-1:0] rs;
        int         dur;
        int         nc;

        // Power-on reset.
        model_reset();
        repeat (2) @(negedge clock);
        check_outputs();
        reset = 1'b0;

        // Nominal frame: expect F210 and no bad digits.
        d0 = done_cnt;
        cyc(1'b1, 7'h7F, 4'b0000);
        hold(7'h40, 4'b0001, 5);
        hold(7'h79, 4'b0010, 5);
        hold(7'h24, 4'b0100, 5);
        hold(7'h0E, 4'b1000, 5);
        cyc(1'b0, 7'h7F, 4'b0000);
        check("nominal_value", value, 16'hF210);
        check("nominal_bad", bad_digit, 4'b0000);
        check("nominal_done_count", done_cnt - d0, 1);

        // Glitch rejection, start while busy, re-seen digit, multi-hot strobe,
        // illegal glyph on digit 2.
        d0 = done_cnt;
        cyc(1'b1, 7'h7F, 4'b0000);
        for (int r = 0; r < 4; r++) begin
            hold(7'h40, 4'b0001, 2);
            hold(7'h79, 4'b0001, 2);
        end
        hold(7'h79, 4'b0001, 4);
        check("glitch_then_hold_digit0", value[3:0], 4'h1);
        cyc(1'b1, 7'h7F, 4'b0000);
        hold(7'h40, 4'b0001, 5);
        check("reseen_digit0_kept", value[3:0], 4'h1);
        hold(7'h40, 4'b0011, 6);
        check("multihot_no_write", value[7:4], 4'h1);
        hold(7'h08, 4'b0010, 5);
        hold(7'h7E, 4'b0100, 5);
        hold(7'h03, 4'b1000, 5);
        cyc(1'b0, 7'h7F, 4'b0000);
        check("mixed_value", value, 16'hB0A1);
        check("mixed_bad", bad_digit, 4'b0100);
        check("mixed_done_count", done_cnt - d0, 1);

        // Timeout: only digits 0..2 are driven, so digit 3 keeps its old value.
        d0 = done_cnt;
        t_at = -1;
        cyc(1'b1, 7'h7F, 4'b0000);
        for (int k = 1; k <= 100; k++) begin
            if (k <= 5)       cyc(1'b0, 7'h12, 4'b0001);
            else if (k <= 10) cyc(1'b0, 7'h02, 4'b0010);
            else if (k <= 15) cyc(1'b0, 7'h78, 4'b0100);
            else              cyc(1'b0, 7'h7F, 4'b0000);
            if (timeout) begin
                t_at = k;
                break;
            end
        end
        done_at_timeout = done_cnt - d0;
        check("timeout_cycle", t_at, TC);
        check("timeout_no_done", done_at_timeout, 0);
        check("timeout_value", value, 16'hB765);
        check("timeout_bad", bad_digit, 4'b0000);
        cyc(1'b0, 7'h7F, 4'b0000);

        // All-off pattern on digit 2.
        cyc(1'b1, 7'h7F, 4'b0000);
        hold(7'h79, 4'b0001, 5);
        hold(7'h24, 4'b0010, 5);
        hold(7'h7F, 4'b0100, 5);
        hold(7'h30, 4'b1000, 5);
        cyc(1'b0, 7'h7F, 4'b0000);
        check("alloff_value", value, 16'h3021);
`ifdef HEX_SEGMENT_BLANK_EN
        check("alloff_bad", bad_digit, 4'b0000);
        check("alloff_blank", blank_digit, 4'b0100);
`else
        check("alloff_bad", bad_digit, 4'b0100);
`endif

        // Randomized scanning frames.
        for (int f = 0; f < 8; f++) begin
            cyc(1'b1, 7'h7F, 4'b0000);
            nc = 0;
            while (nc < 80) begin
                dur = $urandom_range(1, 6);
                if ($urandom_range(0, 7) == 0) rs = ND'($urandom_range(0, 15));
                else                           rs = ND'(1) << $urandom_range(0, ND - 1);
                if ($urandom_range(0, 3) == 0) rh = 7'($urandom_range(0, 127));
                else                           rh = ~GLYPH[$urandom_range(0, 15)];
                for (int k = 0; k < dur; k++) begin
                    cyc(($urandom_range(0, 31) == 0), rh, rs);
                    nc++;
                end
            end
        end

        // Reset in the middle of a frame.
        cyc(1'b1, 7'h7F, 4'b0000);
        hold(7'h40, 4'b0001, 5);
        hold(7'h79, 4'b0010, 2);
        reset = 1'b1;
        #1;
        check("midreset_value", value, 16'h0000);
        check("midreset_bad", bad_digit, 4'b0000);
        check("midreset_busy", busy, 1'b0);
        check("midreset_done", done, 1'b0);
        check("midreset_timeout", timeout, 1'b0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        d0 = done_cnt;
        hold(7'h79, 4'b0010, 40);
        hold(7'h24, 4'b0100, 40);
        check("after_reset_no_done", done_cnt - d0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
